// File: rtl/uart_pkg.sv
// +------------------------------------------------------------+
// | uart_pkg : shared FSM states and constants for the UART RX  |
// | Rev 1.0                                                      |
// +------------------------------------------------------------+
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;

  localparam int DIV_DEFAULT = 100;
  localparam int NBITS       = 8;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// +------------------------------------------------------------+
// | sync_2ff : 1-bit two-flop synchronizer, parameterised reset |
// | Rev 1.0                                                      |
// +------------------------------------------------------------+
`default_nettype none

module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// +------------------------------------------------------------+
// | uart_rx : 8N1 UART receiver with mid-bit sampling           |
// | Rev 1.0                                                      |
// +------------------------------------------------------------+
`default_nettype none

module uart_rx
  import uart_pkg::*;
#(
  parameter int DIV = DIV_DEFAULT,
  parameter int CW  = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_vld,
  output logic       rx_ferr,
  output logic       rx_busy
);

  localparam int             BW      = $clog2(NBITS);
  localparam logic [CW-1:0]  HALF_M1 = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0]  FULL_M1 = CW'(DIV - 1);
  localparam logic [BW-1:0]  LAST    = BW'(NBITS - 1);

  logic rxs;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rxs)
  );

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bit_idx_q, bit_idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_vld_q, rx_vld_d;
  logic            rx_ferr_q, rx_ferr_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    rx_data_d = rx_data_q;
    rx_vld_d  = 1'b0;
    rx_ferr_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxs) state_d = START;
      end
      START: begin
        // Half-bit check rejects glitches shorter than DIV/2 cycles
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (rxs) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_idx_d = '0;
          end
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d     = '0;
          shreg_d   = {rxs, shreg_q[7:1]};
          bit_idx_d = bit_idx_q + BW'(1);
          if (bit_idx_q == LAST) state_d = STOP;
        end
      end
      STOP: begin
        // Leaving at mid-stop-bit lets a back-to-back start edge be caught
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rxs) begin
            rx_data_d = shreg_q;
            rx_vld_d  = 1'b1;
            state_d   = IDLE;
          end else begin
            rx_ferr_d = 1'b1;
            state_d   = BRK;
          end
        end
      end
      BRK: begin
        cnt_d = '0;
        if (rxs) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      rx_data_q <= 8'h00;
      rx_vld_q  <= 1'b0;
      rx_ferr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      rx_data_q <= rx_data_d;
      rx_vld_q  <= rx_vld_d;
      rx_ferr_q <= rx_ferr_d;
    end
  end

  assign rx_data = rx_data_q;
  assign rx_vld  = rx_vld_q;
  assign rx_ferr = rx_ferr_q;
  assign rx_busy = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// +------------------------------------------------------------+
// | tb_uart_rx : self-checking bench for uart_rx (DIV = 100)    |
// | Rev 1.0                                                      |
// +------------------------------------------------------------+
`default_nettype none

module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_vld;
  logic       rx_ferr;
  logic       rx_busy;

  uart_rx #(.DIV(100), .CW(7)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx      (rx),
    .rx_data (rx_data),
    .rx_vld  (rx_vld),
    .rx_ferr (rx_ferr),
    .rx_busy (rx_busy)
  );

  always #5 clk = ~clk;

  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;
  int         ferr_n = 0;
  int         vq_cyc[$];
  logic [7:0] vq_dat[$];

  // Cycle k is the interval after posedge k; strobes are logged 1 time unit after the edge
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (rx_vld) begin
      vq_cyc.push_back(cyc);
      vq_dat.push_back(rx_data);
    end
    if (rx_ferr) ferr_n = ferr_n + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    vq_cyc.delete();
    vq_dat.delete();
    ferr_n = 0;
  endtask

  // Called at a negedge; returns at the negedge ending the stop bit
  task automatic send(input logic [7:0] b, input int per, input logic stopb, output int t0);
    t0 = cyc;
    rx = 1'b0;
    repeat (per) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (per) @(negedge clk);
    end
    rx = stopb;
    repeat (per) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic check_one(input string name, input int t0, input logic [7:0] exp_d);
    chk({name, "_nvld"}, vq_cyc.size(), 1);
    if (vq_cyc.size() > 0) begin
      chk({name, "_lat"}, vq_cyc[0] - t0, 953);
      chk({name, "_dat"}, vq_dat[0], exp_d);
    end
    chk({name, "_ferr"}, ferr_n, 0);
    chk({name, "_hold"}, rx_data, exp_d);
  endtask

  typedef struct {
    logic [7:0] data;
    int         period;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int t0, t1;
    vecs[0] = '{8'h34, 100, 8'h34};
    vecs[1] = '{8'h55,  97, 8'h55};
    vecs[2] = '{8'hAA,  97, 8'hAA};
    vecs[3] = '{8'h55, 103, 8'h55};
    vecs[4] = '{8'hAA, 103, 8'hAA};
    vecs[5] = '{8'h01, 100, 8'h01};
    vecs[6] = '{8'hFE, 100, 8'hFE};

    repeat (5) @(negedge clk);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_vld",  rx_vld,  0);
    chk("rst_ferr", rx_ferr, 0);
    chk("rst_busy", rx_busy, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      clear_log();
      send(vecs[i].data, vecs[i].period, 1'b1, t0);
      repeat (150) @(negedge clk);
      check_one($sformatf("vec%0d", i), t0, vecs[i].exp_data);
    end

    // Back-to-back 0x00 then 0xFF with no gap
    clear_log();
    send(8'h00, 100, 1'b1, t0);
    send(8'hFF, 100, 1'b1, t1);
    repeat (150) @(negedge clk);
    chk("b2b_nvld", vq_cyc.size(), 2);
    if (vq_cyc.size() == 2) begin
      chk("b2b_lat",  vq_cyc[0] - t0, 953);
      chk("b2b_gap",  vq_cyc[1] - vq_cyc[0], 1000);
      chk("b2b_dat0", vq_dat[0], 8'h00);
      chk("b2b_dat1", vq_dat[1], 8'hFF);
    end
    chk("b2b_ferr", ferr_n, 0);

    // 30-cycle glitch: busy spans cycles t0+3..t0+52
    clear_log();
    t0 = cyc;
    rx = 1'b0;
    repeat (30) @(negedge clk);
    rx = 1'b1;
    repeat (22) @(negedge clk);
    chk("gl_busy_hi", rx_busy, 1);
    repeat (1) @(negedge clk);
    chk("gl_busy_lo", rx_busy, 0);
    repeat (200) @(negedge clk);
    chk("gl_nvld", vq_cyc.size(), 0);
    chk("gl_ferr", ferr_n, 0);
    clear_log();
    send(8'hC0, 100, 1'b1, t0);
    repeat (150) @(negedge clk);
    check_one("gl_c0", t0, 8'hC0);

    // Framing error followed by a held-low break
    clear_log();
    send(8'hA5, 100, 1'b0, t0);
    rx = 1'b0;
    repeat (3000) @(negedge clk);
    chk("brk_busy", rx_busy, 1);
    chk("brk_ferr", ferr_n, 1);
    chk("brk_nvld", vq_cyc.size(), 0);
    chk("brk_data", rx_data, 8'hC0);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("brk_idle", rx_busy, 0);
    clear_log();
    send(8'h5A, 100, 1'b1, t0);
    repeat (150) @(negedge clk);
    check_one("brk_5a", t0, 8'h5A);

    // Reset pulse after the 4th data bit of 0x3C
    clear_log();
    t0 = cyc;
    rx = 1'b0;
    repeat (100) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = (8'h3C >> i) & 1;
      repeat (100) @(negedge clk);
    end
    chk("mr_busy_pre", rx_busy, 1);
    rx = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mr_busy", rx_busy, 0);
    chk("mr_data", rx_data, 8'h00);
    repeat (1200) @(negedge clk);
    chk("mr_nvld", vq_cyc.size(), 0);
    chk("mr_ferr", ferr_n, 0);
    clear_log();
    send(8'h81, 100, 1'b1, t0);
    repeat (150) @(negedge clk);
    check_one("mr_81", t0, 8'h81);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver that turns the serial RsRx line from the host UART into parallel bytes.
- It is the receive-side counterpart of the board's existing RsTx transmit path.
- Each good byte is presented on rx_data with a one-cycle rx_vld strobe, for use by the instruction front end (an alternative instruction source to the sw/btnS pair).
- Runs on the 100 MHz board clock; default baud is 1,000,000.

Parameters:
- DIV, 100, clock cycles per bit (clk_freq / baud); must be even and >= 4.
- CW, 7, counter width; must satisfy 2^CW > DIV.

Ports:
- clk  input  1  board clock, 100 MHz
- rst_n  input  1  synchronous active-low reset
- rx  input  1  asynchronous serial line (RsRx); idles high
- rx_data  output  8  last correctly received byte
- rx_vld  output  1  one-cycle pulse; rx_data is updated in the same cycle
- rx_ferr  output  1  one-cycle pulse on stop-bit error
- rx_busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Clocking and reset: one clock domain, clk. rst_n is synchronous and active-low, sampled on the rising edge of clk.
- Reset values:
  - rx_data = 8'h00; rx_vld, rx_ferr, rx_busy = 0.
  - Synchronizer flops = 1; FSM = IDLE; bit counter and shift register = 0.
- Input sync: rx passes through a 2-flop synchronizer; rxs (the synchronized line) lags the pin by 2 clocks. Only rxs is used by the FSM.
- Frame timing:
  - Let n be the first cycle in IDLE with rxs==0.
  - Sample points fall at n + DIV/2 + k*DIV: k=0 start bit, k=1..8 data bits LSB first, k=9 stop bit.
  - A cycle counter (CW bits) reloads at each state entry and at each sample.
- FSM:
  - IDLE: rxs==0 -> START, counter cleared.
  - START: at the half-bit point, if rxs==1 the low pulse was a glitch -> IDLE with no output. If rxs==0 -> DATA with bit index 0.
  - DATA: sample every DIV cycles and shift right into shreg[7]. After the 8th sample -> STOP.
  - STOP: after DIV cycles sample rxs.
    - rxs==1: rx_data <= shreg, rx_vld=1 for exactly the next cycle (n + DIV/2 + 9*DIV + 1), then -> IDLE.
    - rxs==0: rx_ferr=1 for one cycle, rx_data unchanged, -> BRK.
  - BRK: wait until rxs==1, then -> IDLE. This stops a held-low line (break) from being read as repeated 0x00 frames.
- Back-to-back frames: IDLE is re-entered mid-stop-bit, so a start edge arriving DIV/2 cycles after the stop sample is caught. No inter-frame gap is required.
- No flow control: rx_vld is not acknowledged. A consumer that misses a strobe loses the byte. rx_data holds its value until the next good frame.
- rx_busy is 1 in START, DATA, STOP and BRK.
- Reset mid-frame aborts the frame. Outputs return to reset values the cycle after rst_n is sampled low, with no rx_vld or rx_ferr. The first frame after reset release is received normally.
- Timing tolerance: sampling at mid-bit tolerates about ±4% baud mismatch over 10 bits.

Decomposition:
- Shared package uart_pkg:
  - state typedef {IDLE, START, DATA, STOP, BRK}
  - localparam DIV_DEFAULT = 100
  - localparam NBITS = 8
- One sub-module, sync_2ff: a 1-bit two-flop synchronizer with a reset value parameter (set to 1 here). It is reusable by any other asynchronous input such as the buttons.

Test Plan:
- Send 0x34 at DIV=100, pin falling edge at cycle t -> rx_vld high only in cycle t+2+951, rx_data=0x34, rx_ferr never high.
- Send 0x00 then 0xFF back-to-back, each with one stop bit -> two rx_vld pulses exactly 1000 cycles apart, data 0x00 then 0xFF.
- Drive a 30-cycle low glitch on the idle line -> no rx_vld or rx_ferr; rx_busy returns to 0 within DIV/2+3 cycles; a following 0xC0 is received correctly.
- Send 0xA5 with stop bit 0, then hold the line low for 3000 cycles -> exactly one rx_ferr pulse, rx_data keeps its prior value, no rx_vld. After the line goes high, 0x5A is received.
- Assert rst_n=0 for 1 cycle after the 4th data bit of 0x3C -> rx_busy=0 and rx_data=0x00 next cycle, no strobes. A subsequent 0x81 frame is received correctly.
- Drive frames with a bit period of 97 and of 103 cycles, bytes 0x55 and 0xAA -> all four bytes received correctly, rx_ferr never asserted.
